line_seg_fifo: RTL and testbench

- Parametrised line-segment queue between the AVG core (producer of start/end/colour segments) and the line rasteriser (consumer).
- Generalises the fixed 8-entry, write-only line register queue:
  - configurable coordinate width, colour width and depth;
  - valid/ready handshake on both sides;
  - almost-full back-pressure, frame flush and a sticky drop flag.
- First-word-fall-through: the head entry is presented on out_* whenever out_valid is high.

---
 rtl/line_seg_pkg.sv | 20 ++
 rtl/line_seg_fifo_mem.sv | 31 +++
 rtl/line_seg_fifo.sv | 149 ++++++++++++++
 tb/tb_line_seg_fifo.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/line_seg_pkg.sv
// Shared types for the vector line path between the AVG core and the
// line rasteriser.
//   COORD_W_DEF / COLOR_W_DEF : default coordinate and colour widths
//   LINE_FIFO_DEPTH_DEF       : default segment queue depth
//   line_seg_t                : one line segment (start, end, colour)
package line_seg_pkg;

  localparam int COORD_W_DEF         = 11;
  localparam int COLOR_W_DEF         = 3;
  localparam int LINE_FIFO_DEPTH_DEF = 8;

  typedef struct packed {
    logic [COORD_W_DEF-1:0] start_x;
    logic [COORD_W_DEF-1:0] start_y;
    logic [COORD_W_DEF-1:0] end_x;
    logic [COORD_W_DEF-1:0] end_y;
    logic [COLOR_W_DEF-1:0] color;
  } line_seg_t;

endpackage

// File: rtl/line_seg_fifo_mem.sv
// Register array backing the line segment queue.
// One synchronous write port, one asynchronous (combinational) read port.
// The array is deliberately not reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, combinational from raddr_i
module line_seg_fifo_mem #(
  parameter  int WIDTH = 47,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/line_seg_fifo.sv
// First-word-fall-through line segment queue between the AVG core
// (producer) and the line rasteriser (consumer).
//   clk, rst (sync, active-high), flush   : clocking / frame restart
//   in_valid/in_ready, in_*               : producer side
//   out_valid/out_ready, out_*            : consumer side, head shown while valid
//   count, almost_full, dropped           : occupancy and sticky overflow flag
// Optional build macro LINE_SEG_FIFO_STATS_EN adds drop_count (saturating
// count of discarded pushes) and high_water (peak occupancy).
module line_seg_fifo
  import line_seg_pkg::*;
#(
  parameter  int COORD_W   = COORD_W_DEF,
  parameter  int COLOR_W   = COLOR_W_DEF,
  parameter  int DEPTH     = LINE_FIFO_DEPTH_DEF,
  parameter  int AF_THRESH = DEPTH - 2,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_start_x,
  input  logic [COORD_W-1:0] in_start_y,
  input  logic [COORD_W-1:0] in_end_x,
  input  logic [COORD_W-1:0] in_end_y,
  input  logic [COLOR_W-1:0] in_color,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_start_x,
  output logic [COORD_W-1:0] out_start_y,
  output logic [COORD_W-1:0] out_end_x,
  output logic [COORD_W-1:0] out_end_y,
  output logic [COLOR_W-1:0] out_color,
  output logic [CW-1:0]      count,
  output logic               almost_full,
  output logic               dropped
`ifdef LINE_SEG_FIFO_STATS_EN
  ,
  output logic [15:0]        drop_count,
  output logic [CW-1:0]      high_water
`endif
);

  localparam int EW = 4 * COORD_W + COLOR_W;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          dropped_q, dropped_d;
  logic          full, push, pop, wr_en;
  logic [EW-1:0] wr_data, rd_data;

  assign full        = (count_q == CW'(DEPTH));
  assign in_ready    = !full;
  assign out_valid   = (count_q != '0);
  assign push        = in_valid && !full;
  assign pop         = out_valid && out_ready;
  assign almost_full = (count_q >= CW'(AF_THRESH));
  assign count       = count_q;
  assign dropped     = dropped_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dropped_d = dropped_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      dropped_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      // a pop in the same cycle does not make room for this push
      if (in_valid && full) dropped_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
    end
  end

  // flush discards a same-cycle push, so the array is left untouched
  assign wr_en   = push && !flush;
  assign wr_data = {in_start_x, in_start_y, in_end_x, in_end_y, in_color};

  line_seg_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // stale array contents are never exposed while the queue is empty
  assign {out_start_x, out_start_y, out_end_x, out_end_y, out_color} =
    out_valid ? rd_data : '0;

`ifdef LINE_SEG_FIFO_STATS_EN
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] hw_q, hw_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    hw_d       = hw_q;
    if (flush) begin
      drop_cnt_d = '0;
      hw_d       = '0;
    end else begin
      if (in_valid && full && (drop_cnt_q != 16'hFFFF))
        drop_cnt_d = drop_cnt_q + 16'd1;
      // track post-edge occupancy
      if (count_d > hw_q) hw_d = count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
      hw_q       <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      hw_q       <= hw_d;
    end
  end

  assign drop_count = drop_cnt_q;
  assign high_water = hw_q;
`endif

endmodule

// File: tb/tb_line_seg_fifo.sv
// Self-checking bench for line_seg_fifo (default parameters, DEPTH=8).
// Directed scenarios plus a randomized run against a queue-based model.
// Build with LINE_SEG_FIFO_STATS_EN to also exercise drop_count/high_water.
module tb_line_seg_fifo;
  import line_seg_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic in_ready, out_valid, almost_full, dropped;
  logic [10:0] in_start_x, in_start_y, in_end_x, in_end_y;
  logic [2:0]  in_color;
  logic [10:0] out_start_x, out_start_y, out_end_x, out_end_y;
  logic [2:0]  out_color;
  logic [CW-1:0] count;
`ifdef LINE_SEG_FIFO_STATS_EN
  logic [15:0]   drop_count;
  logic [CW-1:0] high_water;
`endif
  line_seg_t out_seg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign out_seg = {out_start_x, out_start_y, out_end_x, out_end_y, out_color};

  line_seg_fifo dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_start_x(in_start_x), .in_start_y(in_start_y),
    .in_end_x(in_end_x), .in_end_y(in_end_y), .in_color(in_color),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_start_x(out_start_x), .out_start_y(out_start_y),
    .out_end_x(out_end_x), .out_end_y(out_end_y), .out_color(out_color),
    .count(count), .almost_full(almost_full), .dropped(dropped)
`ifdef LINE_SEG_FIFO_STATS_EN
    , .drop_count(drop_count), .high_water(high_water)
`endif
  );

  function automatic line_seg_t mk(input int sx, input int sy, input int ex,
                                   input int ey, input int c);
    line_seg_t s;
    s.start_x = 11'(sx);
    s.start_y = 11'(sy);
    s.end_x   = 11'(ex);
    s.end_y   = 11'(ey);
    s.color   = 3'(c);
    return s;
  endfunction

  function automatic line_seg_t seg_id(input int id);
    return mk(id, id + 1, id + 2, id + 3, id);
  endfunction

  task automatic drive(input logic v, input line_seg_t s, input logic r, input logic f);
    in_valid = v;
    {in_start_x, in_start_y, in_end_x, in_end_y, in_color} = s;
    out_ready = r;
    flush = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (almost_full !== 1'b0 || dropped !== 1'b0) begin errors++; $display("FAIL reset_flags got af=%b dr=%b exp 0 0", almost_full, dropped); end
    checks++; if (out_seg !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_seg); end
  endtask

  task automatic test_single();
    line_seg_t s;
    s = mk(10, 20, 30, 40, 5);
    drive(1'b1, s, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
    checks++; if (out_seg !== s) begin errors++; $display("FAIL single_data got %h exp %h", out_seg, s); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_pop got cnt=%0d v=%b exp 0 0", count, out_valid); end
    checks++; if (out_seg !== '0) begin errors++; $display("FAIL single_pop_data got %h exp 0", out_seg); end
  endtask

  task automatic test_fill_drain();
    clear();
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (almost_full !== (i >= 6)) begin errors++; $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full, (i >= 6)); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got %b exp 1", i, in_ready); end
      drive(1'b1, mk(i, i, i + 1, i + 1, i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (count !== 4'd8 || in_ready !== 1'b0 || almost_full !== 1'b1) begin errors++; $display("FAIL full_state got cnt=%0d rdy=%b af=%b exp 8 0 1", count, in_ready, almost_full); end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL full_no_drop got %b exp 0", dropped); end
    drive(1'b1, mk(99, 99, 99, 99, 1), 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (dropped !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL ninth_push got dr=%b cnt=%0d exp 1 8", dropped, count); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (out_valid !== 1'b1 || out_seg !== mk(i, i, i + 1, i + 1, i)) begin errors++; $display("FAIL drain[%0d] got v=%b %h exp 1 %h", i, out_valid, out_seg, mk(i, i, i + 1, i + 1, i)); end
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (count !== 4'd0 || out_valid !== 1'b0 || dropped !== 1'b1) begin errors++; $display("FAIL drained got cnt=%0d v=%b dr=%b exp 0 0 1", count, out_valid, dropped); end
  endtask

  task automatic test_wrap();
    int nxt_push, nxt_pop;
    clear();
    nxt_push = 100;
    nxt_pop  = 100;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, seg_id(nxt_push), 1'b0, 1'b0);
      nxt_push++;
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      checks++; if (out_seg !== seg_id(nxt_pop) || count !== 4'd3) begin errors++; $display("FAIL wrap[%0d] got cnt=%0d %h exp 3 %h", i, count, out_seg, seg_id(nxt_pop)); end
      drive(1'b1, seg_id(nxt_push), 1'b1, 1'b0);
      nxt_push++;
      nxt_pop++;
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (count !== 4'd3 || out_seg !== seg_id(nxt_pop)) begin errors++; $display("FAIL wrap_end got cnt=%0d %h exp 3 %h", count, out_seg, seg_id(nxt_pop)); end
  endtask

  task automatic test_flush();
    clear();
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1'b1, seg_id(200 + i), 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
    end
    checks++; if (count !== 4'd5 || dropped !== 1'b1) begin errors++; $display("FAIL preflush got cnt=%0d dr=%b exp 5 1", count, dropped); end
    drive(1'b1, seg_id(77), 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (count !== 4'd0 || out_valid !== 1'b0 || dropped !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush got cnt=%0d v=%b dr=%b rdy=%b exp 0 0 0 1", count, out_valid, dropped, in_ready); end
    tick();
    checks++; if (count !== 4'd0 || out_valid !== 1'b0 || out_seg !== '0) begin errors++; $display("FAIL flush_absent got cnt=%0d v=%b %h exp 0 0 0", count, out_valid, out_seg); end
  endtask

`ifdef LINE_SEG_FIFO_STATS_EN
  task automatic test_stats();
    clear();
    for (int i = 0; i < DEPTH + 3; i++) begin
      drive(1'b1, seg_id(300 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (drop_count !== 16'd3 || high_water !== 4'd8) begin errors++; $display("FAIL stats got dc=%0d hw=%0d exp 3 8", drop_count, high_water); end
    clear();
    checks++; if (drop_count !== 16'd0 || high_water !== 4'd0) begin errors++; $display("FAIL stats_flush got dc=%0d hw=%0d exp 0 0", drop_count, high_water); end
  endtask
`endif

  task automatic test_random();
    line_seg_t mq[$];
    line_seg_t s, exp_seg;
    logic v, r, f, m_dropped, m_full, m_push, m_pop;
    int m_dc, m_hw, vb, rb;
    clear();
    m_dropped = 1'b0;
    m_dc = 0;
    m_hw = 0;
    for (int n = 0; n < 2000; n++) begin
      vb = ((n / 200) % 2 == 0) ? 75 : 30;
      rb = ((n / 200) % 2 == 0) ? 30 : 75;
      v = ($urandom_range(0, 99) < vb);
      r = ($urandom_range(0, 99) < rb);
      f = ($urandom_range(0, 79) == 0);
      s = line_seg_t'({$urandom, $urandom});
      exp_seg = (mq.size() != 0) ? mq[0] : '0;
      checks++;
      if (count !== CW'(mq.size()) || out_valid !== (mq.size() != 0) ||
          in_ready !== (mq.size() != DEPTH) || almost_full !== (mq.size() >= DEPTH - 2) ||
          dropped !== m_dropped || out_seg !== exp_seg) begin
        errors++;
        $display("FAIL rand[%0d] got cnt=%0d v=%b rdy=%b af=%b dr=%b %h exp cnt=%0d dr=%b %h",
                 n, count, out_valid, in_ready, almost_full, dropped, out_seg,
                 mq.size(), m_dropped, exp_seg);
      end
`ifdef LINE_SEG_FIFO_STATS_EN
      checks++;
      if (drop_count !== 16'(m_dc) || high_water !== CW'(m_hw)) begin
        errors++;
        $display("FAIL rand_stats[%0d] got dc=%0d hw=%0d exp %0d %0d", n, drop_count, high_water, m_dc, m_hw);
      end
`endif
      drive(v, s, r, f);
      tick();
      if (f) begin
        mq.delete();
        m_dropped = 1'b0;
        m_dc = 0;
        m_hw = 0;
      end else begin
        m_full = (mq.size() == DEPTH);
        m_push = v && !m_full;
        m_pop  = r && (mq.size() != 0);
        if (v && m_full) begin
          m_dropped = 1'b1;
          if (m_dc < 65535) m_dc++;
        end
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back(s);
        if (mq.size() > m_hw) m_hw = mq.size();
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    test_reset();
    test_single();
    test_fill_drain();
    test_wrap();
    test_flush();
`ifdef LINE_SEG_FIFO_STATS_EN
    test_stats();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
